// File: rtl/adsr_envelope.sv
// Linear attack/decay/sustain/release envelope generator for one voice, advanced on the sample strobe.
// Define ADSR_HARD_RETRIG_EN to restart every note-on from silence instead of continuing from the current level.
module adsr_envelope #(
    parameter int ENV_WIDTH = 16,
    parameter int ACC_WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 En,
    input  logic                 gate,
    input  logic [ACC_WIDTH-1:0] attackRate,
    input  logic [ACC_WIDTH-1:0] decayRate,
    input  logic [ACC_WIDTH-1:0] releaseRate,
    input  logic [ENV_WIDTH-1:0] sustainLevel,
    output logic [ENV_WIDTH-1:0] env,
    output logic [2:0]           state,
    output logic                 active
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

    state_t               state_reg;
    logic [ACC_WIDTH-1:0] acc_reg;
    logic                 gate_d_reg;
    logic                 active_reg;

    logic [ACC_WIDTH-1:0] target;
    logic [ACC_WIDTH:0]   attack_sum;
    logic [ACC_WIDTH:0]   decay_limit;
    logic                 rise;
    logic                 fall;

    // Sustain level sits in the top bits of the accumulator scale.
    generate
        if (ACC_WIDTH == ENV_WIDTH) begin : g_target_full
            assign target = sustainLevel;
        end else begin : g_target_pad
            assign target = {sustainLevel, {(ACC_WIDTH-ENV_WIDTH){1'b0}}};
        end
    endgenerate

    assign attack_sum  = {1'b0, acc_reg} + {1'b0, attackRate};
    assign decay_limit = {1'b0, target} + {1'b0, decayRate};
    assign rise        = gate & ~gate_d_reg;
    assign fall        = ~gate & gate_d_reg;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            gate_d_reg <= 1'b0;
            active_reg <= 1'b0;
        end else if (En) begin
            gate_d_reg <= gate;
            if (rise) begin
                state_reg  <= ATTACK;
                active_reg <= 1'b1;
`ifdef ADSR_HARD_RETRIG_EN
                acc_reg    <= '0;
`endif
            end else if (fall && (state_reg == ATTACK || state_reg == DECAY ||
                                  state_reg == SUSTAIN)) begin
                state_reg  <= RELEASE;
                active_reg <= 1'b1;
            end else begin
                case (state_reg)
                    ATTACK: begin
                        active_reg <= 1'b1;
                        if (attack_sum[ACC_WIDTH] || attack_sum[ACC_WIDTH-1:0] == ACC_MAX) begin
                            acc_reg   <= ACC_MAX;
                            state_reg <= DECAY;
                        end else begin
                            acc_reg <= attack_sum[ACC_WIDTH-1:0];
                        end
                    end
                    DECAY: begin
                        active_reg <= 1'b1;
                        if ({1'b0, acc_reg} <= decay_limit) begin
                            acc_reg   <= target;
                            state_reg <= SUSTAIN;
                        end else begin
                            acc_reg <= acc_reg - decayRate;
                        end
                    end
                    SUSTAIN: begin
                        active_reg <= 1'b1;
                        acc_reg    <= target;
                    end
                    RELEASE: begin
                        if (acc_reg <= releaseRate) begin
                            acc_reg    <= '0;
                            state_reg  <= IDLE;
                            active_reg <= 1'b0;
                        end else begin
                            acc_reg    <= acc_reg - releaseRate;
                            active_reg <= 1'b1;
                        end
                    end
                    default: begin
                        // IDLE, and recovery from any illegal code.
                        acc_reg    <= '0;
                        state_reg  <= IDLE;
                        active_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign env    = acc_reg[ACC_WIDTH-1 -: ENV_WIDTH];
    assign state  = state_reg;
    assign active = active_reg;

endmodule

// File: tb/tb_adsr_envelope.sv
// Scoreboard bench for adsr_envelope: expected outputs are queued per En tick and compared after the tick.
module tb_adsr_envelope;

    logic        Clk;
    logic        Reset_n;
    logic        En;
    logic        gate;
    logic [31:0] attackRate;
    logic [31:0] decayRate;
    logic [31:0] releaseRate;
    logic [15:0] sustainLevel;
    logic [15:0] env;
    logic [2:0]  state;
    logic        active;

    int checks_total;
    int checks_passed;

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [15:0] ev;
        logic        act;
    } exp_t;

    exp_t exp_q[$];

    adsr_envelope #(.ENV_WIDTH(16), .ACC_WIDTH(32)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .En           (En),
        .gate         (gate),
        .attackRate   (attackRate),
        .decayRate    (decayRate),
        .releaseRate  (releaseRate),
        .sustainLevel (sustainLevel),
        .env          (env),
        .state        (state),
        .active       (active)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One En pulse every 4 clocks; the expected result is queued before the strobe.
    task automatic en_tick(input string tag, input logic [2:0] st, input logic [15:0] ev,
                           input logic act);
        exp_t e;
        exp_q.push_back('{tag, st, ev, act});
        repeat (3) @(negedge Clk);
        En = 1'b1;
        @(negedge Clk);
        En = 1'b0;
        e = exp_q.pop_front();
        check_val({e.tag, ".state"},  {29'd0, state}, {29'd0, e.st});
        check_val({e.tag, ".env"},    {16'd0, env},   {16'd0, e.ev});
        check_val({e.tag, ".active"}, {31'd0, active}, {31'd0, e.act});
        $display("tick %-12s state=%0d env=0x%04h active=%0b", e.tag, state, env, active);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        Reset_n      = 1'b0;
        En           = 1'b0;
        gate         = 1'b0;
        attackRate   = 32'h4000_0000;
        decayRate    = 32'h2000_0000;
        releaseRate  = 32'h4000_0000;
        sustainLevel = 16'h8000;
        #1;
        check_val("rst.state",  {29'd0, state}, 32'd0);
        check_val("rst.env",    {16'd0, env},   32'd0);
        check_val("rst.active", {31'd0, active}, 32'd0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;

        // Attack
        gate = 1'b1;
        en_tick("att.rise", 3'd1, 16'h0000, 1'b1);
        en_tick("att.1",    3'd1, 16'h4000, 1'b1);

        // En held low while gate toggles: nothing may move or be detected
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            gate = ~gate;
        end
        check_val("gating.state", {29'd0, state}, 32'd1);
        check_val("gating.env",   {16'd0, env},   32'h4000);
        en_tick("att.2",    3'd1, 16'h8000, 1'b1);
        en_tick("att.3",    3'd1, 16'hC000, 1'b1);
        en_tick("att.top",  3'd2, 16'hFFFF, 1'b1);

        // Decay to sustain, then live sustain tracking
        en_tick("dec.1",    3'd2, 16'hDFFF, 1'b1);
        en_tick("dec.2",    3'd2, 16'hBFFF, 1'b1);
        en_tick("dec.3",    3'd2, 16'h9FFF, 1'b1);
        en_tick("dec.end",  3'd3, 16'h8000, 1'b1);
        sustainLevel = 16'h6000;
        en_tick("sus.6000", 3'd3, 16'h6000, 1'b1);
        sustainLevel = 16'h8000;
        en_tick("sus.8000", 3'd3, 16'h8000, 1'b1);

        // Release to idle
        gate = 1'b0;
        en_tick("rel.fall", 3'd4, 16'h8000, 1'b1);
        en_tick("rel.1",    3'd4, 16'h4000, 1'b1);
        en_tick("rel.end",  3'd0, 16'h0000, 1'b0);
        en_tick("idle",     3'd0, 16'h0000, 1'b0);

        // Note-on, early note-off in ATTACK, retrigger in RELEASE at 0x4000
        gate = 1'b1;
        en_tick("n2.rise",  3'd1, 16'h0000, 1'b1);
        en_tick("n2.att",   3'd1, 16'h4000, 1'b1);
        gate = 1'b0;
        en_tick("n2.fall",  3'd4, 16'h4000, 1'b1);
        gate = 1'b1;
`ifdef ADSR_HARD_RETRIG_EN
        en_tick("retrig",   3'd1, 16'h0000, 1'b1);
        en_tick("retrig.1", 3'd1, 16'h4000, 1'b1);
        en_tick("retrig.2", 3'd1, 16'h8000, 1'b1);
`else
        en_tick("retrig",   3'd1, 16'h4000, 1'b1);
        en_tick("retrig.1", 3'd1, 16'h8000, 1'b1);
`endif
        en_tick("r.att",    3'd1, 16'hC000, 1'b1);
        en_tick("r.top",    3'd2, 16'hFFFF, 1'b1);
        en_tick("r.dec",    3'd2, 16'hDFFF, 1'b1);

        // Asynchronous reset between clock edges in DECAY
        #2;
        Reset_n = 1'b0;
        #1;
        check_val("arst.state",  {29'd0, state}, 32'd0);
        check_val("arst.env",    {16'd0, env},   32'd0);
        check_val("arst.active", {31'd0, active}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // gate still high after reset is a rise; attack sum hitting MAX exactly,
        // and full-scale sustain finishing decay on its first tick
        attackRate   = 32'hFFFF_FFFF;
        sustainLevel = 16'hFFFF;
        en_tick("p.rise",   3'd1, 16'h0000, 1'b1);
        en_tick("p.max",    3'd2, 16'hFFFF, 1'b1);
        en_tick("p.sus",    3'd3, 16'hFFFF, 1'b1);

        // Zero release rate holds the level
        releaseRate = 32'd0;
        gate = 1'b0;
        en_tick("z.fall",   3'd4, 16'hFFFF, 1'b1);
        en_tick("z.hold",   3'd4, 16'hFFFF, 1'b1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
